// File: rtl/fifo_burst_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_writer
//  Description : Generates a burst of len bytes into a write-side FIFO.
//                The data source is a constant, an increment, an LFSR or an
//                external stream. Optional idle gap cycles follow each beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_writer #(
    parameter int unsigned GAP = 0
) (
    input  logic       clkw,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] len,
    input  logic [1:0] mode,
    input  logic [7:0] seed,
    input  logic       abort,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       f,
    output logic       WREQ,
    output logic [7:0] WD,
    output logic       busy,
    output logic       done,
    output logic [8:0] count
);

    localparam logic [3:0] c_GAP_LOAD  = 4'(GAP);
    localparam logic [1:0] c_MODE_CONST = 2'b00;
    localparam logic [1:0] c_MODE_INC   = 2'b01;
    localparam logic [1:0] c_MODE_LFSR  = 2'b10;
    localparam logic [1:0] c_MODE_EXT   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] len_q, len_d;
    logic [8:0] count_q, count_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] wd_q, wd_d;
    logic       hold_valid_q, hold_valid_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;

    logic       w_beat;
    logic [7:0] w_wd_next;

    // Write strobe and handshake outputs are decoded directly from state
    assign WREQ      = (state_q == S_WRITE) && hold_valid_q && !f;
    assign din_ready = (state_q == S_WRITE) && !hold_valid_q;
    assign busy      = (state_q == S_WRITE) || (state_q == S_GAP);
    assign done      = (state_q == S_DONE);
    assign WD        = wd_q;
    assign count     = count_q;
    assign w_beat    = WREQ;

    // Data value that follows the current one after an accepted beat
    always_comb begin
        w_wd_next = wd_q;
        case (mode_q)
            c_MODE_CONST: w_wd_next = wd_q;
            c_MODE_INC:   w_wd_next = wd_q + 8'd1;
            c_MODE_LFSR:  w_wd_next = {wd_q[6:0], wd_q[7] ^ wd_q[5] ^ wd_q[4] ^ wd_q[3]};
            default:      w_wd_next = wd_q;
        endcase
    end

    // Next-state logic for the burst controller and its datapath registers
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        count_d      = count_q;
        mode_d       = mode_q;
        wd_d         = wd_q;
        hold_valid_d = hold_valid_q;
        gap_cnt_d    = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = 9'd0;
                    if (len != 9'd0) begin
                        len_d   = len;
                        mode_d  = mode;
                        state_d = S_WRITE;
                        if (mode == c_MODE_EXT) begin
                            hold_valid_d = 1'b0;
                        end else begin
                            hold_valid_d = 1'b1;
                            // An all-zero LFSR would lock up, so it starts at 1
                            wd_d = ((mode == c_MODE_LFSR) && (seed == 8'h00)) ? 8'h01 : seed;
                        end
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_d      = S_IDLE;
                    hold_valid_d = 1'b0;
                end else if (w_beat) begin
                    count_d = count_q + 9'd1;
                    if (mode_q == c_MODE_EXT) begin
                        hold_valid_d = 1'b0;
                    end else begin
                        wd_d = w_wd_next;
                    end
                    if ((count_q + 9'd1) == len_q) begin
                        state_d      = S_DONE;
                        hold_valid_d = 1'b0;
                    end else if (c_GAP_LOAD != 4'd0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = c_GAP_LOAD;
                    end
                end else if (din_valid && din_ready) begin
                    wd_d         = din;
                    hold_valid_d = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d      = S_IDLE;
                    hold_valid_d = 1'b0;
                    gap_cnt_d    = 4'd0;
                end else if (gap_cnt_q <= 4'd1) begin
                    gap_cnt_d = 4'd0;
                    state_d   = S_WRITE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clkw or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_q        <= 9'd0;
            count_q      <= 9'd0;
            mode_q       <= 2'b00;
            wd_q         <= 8'h00;
            hold_valid_q <= 1'b0;
            gap_cnt_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            count_q      <= count_d;
            mode_q       <= mode_d;
            wd_q         <= wd_d;
            hold_valid_q <= hold_valid_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_burst_writer
//  Description : Self-checking bench for fifo_burst_writer, with one instance
//                at GAP=0 and one at GAP=3 sharing the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_writer;

    logic       clkw = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [8:0] len = 9'd0;
    logic [1:0] mode = 2'd0;
    logic [7:0] seed = 8'd0;
    logic       abort = 1'b0;
    logic [7:0] din = 8'd0;
    logic       din_valid = 1'b0;
    logic       f = 1'b0;

    logic       din_ready0, wreq0, busy0, done0;
    logic [7:0] wd0;
    logic [8:0] count0;
    logic       din_ready3, wreq3, busy3, done3;
    logic [7:0] wd3;
    logic [8:0] count3;

    int checks = 0;
    int errors = 0;
    int dn0 = 0;
    int dn3 = 0;

    logic [7:0] q0[$];
    logic [7:0] q3[$];
    logic [7:0] src0[$];
    logic [7:0] src3[$];
    logic [7:0] expg[$];
    int         bt[$];

    fifo_burst_writer #(.GAP(0)) dut0 (
        .clkw(clkw), .rst(rst), .start(start), .len(len), .mode(mode), .seed(seed),
        .abort(abort), .din(din), .din_valid(din_valid), .din_ready(din_ready0),
        .f(f), .WREQ(wreq0), .WD(wd0), .busy(busy0), .done(done0), .count(count0)
    );

    fifo_burst_writer #(.GAP(3)) dut3 (
        .clkw(clkw), .rst(rst), .start(start), .len(len), .mode(mode), .seed(seed),
        .abort(abort), .din(din), .din_valid(din_valid), .din_ready(din_ready3),
        .f(f), .WREQ(wreq3), .WD(wd3), .busy(busy3), .done(done3), .count(count3)
    );

    always #5 clkw = ~clkw;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clkw);
        #1;
    endtask

    // FIFO-side observer: captures written bytes, consumed din and done pulses
    always @(posedge clkw) begin
        if (rst) begin
            if (wreq0) q0.push_back(wd0);
            if (wreq3) q3.push_back(wd3);
            if (din_valid && din_ready0) src0.push_back(din);
            if (din_valid && din_ready3) src3.push_back(din);
            if (done0) dn0 <= dn0 + 1;
            if (done3) dn3 <= dn3 + 1;
        end
    end

    // A write must never be requested while the FIFO reports full
    always @(negedge clkw) begin
        if (rst && f) begin
            chk("wreq_while_full0", {31'd0, wreq0}, 32'd0);
            chk("wreq_while_full3", {31'd0, wreq3}, 32'd0);
        end
    end

    task automatic reset_sync();
        start = 0; abort = 0; f = 0; din_valid = 0;
        rst = 0;
        tick(); tick();
        rst = 1;
        tick();
    endtask

    // Expected byte stream for the generated modes, from the data-source rules
    task automatic build_exp(input logic [8:0] l, input logic [1:0] m, input logic [7:0] s);
        logic [7:0] v;
        expg.delete();
        v = (m == 2'd2 && s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < int'(l); i++) begin
            expg.push_back(v);
            if (m == 2'd1) v = v + 8'd1;
            else if (m == 2'd2) v = {v[6:0], ^(v & 8'hB8)};
        end
    endtask

    task automatic run_burst(input logic [8:0] l, input logic [1:0] m, input logic [7:0] s, input bit rf);
        int n, d0, d3, bad0, bad3;
        q0.delete(); q3.delete(); src0.delete(); src3.delete();
        d0 = dn0; d3 = dn3;
        start = 1; len = l; mode = m; seed = s; f = 0; din_valid = 0;
        tick();
        start = 0;
        n = 0;
        while ((dn0 == d0 || dn3 == d3) && n < 4000) begin
            f = rf && ($urandom_range(0, 3) == 0);
            din_valid = ($urandom_range(0, 1) == 1);
            din = 8'($urandom);
            tick();
            n++;
        end
        f = 0; din_valid = 0;
        chk("burst_timeout", {31'd0, n < 4000}, 32'd1);
        repeat (3) tick();
        chk("done_pulses0", dn0 - d0, 1);
        chk("done_pulses3", dn3 - d3, 1);
        chk("count0", {23'd0, count0}, {23'd0, l});
        chk("count3", {23'd0, count3}, {23'd0, l});
        chk("beats0", q0.size(), {23'd0, l});
        chk("beats3", q3.size(), {23'd0, l});
        build_exp(l, m, s);
        bad0 = 0; bad3 = 0;
        for (int i = 0; i < q0.size(); i++) begin
            if (m == 2'd3) begin
                if (i >= src0.size() || q0[i] !== src0[i]) bad0++;
            end else if (i >= expg.size() || q0[i] !== expg[i]) bad0++;
        end
        for (int i = 0; i < q3.size(); i++) begin
            if (m == 2'd3) begin
                if (i >= src3.size() || q3[i] !== src3[i]) bad3++;
            end else if (i >= expg.size() || q3[i] !== expg[i]) bad3++;
        end
        chk("data0", bad0, 0);
        chk("data3", bad3, 0);
    endtask

    typedef struct {
        logic       start;
        logic [8:0] len;
        logic [1:0] mode;
        logic [7:0] seed;
        logic       f;
        logic       e_wreq;
        logic [7:0] e_wd;
        logic       e_busy;
        logic       e_done;
        logic [8:0] e_count;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int c, d, bad;
        logic [8:0] l;
        logic [1:0] m;
        logic [7:0] s;
        bit rf;

        // LFSR burst of 4 with one stall, start ignored while busy, then len=0
        tbl[0] = '{1'b1, 9'd4, 2'd2, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0};
        tbl[1] = '{1'b0, 9'd0, 2'd0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 9'd0};
        tbl[2] = '{1'b1, 9'd9, 2'd0, 8'hAA, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 9'd1};
        tbl[3] = '{1'b0, 9'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h04, 1'b1, 1'b0, 9'd2};
        tbl[4] = '{1'b0, 9'd0, 2'd0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 9'd2};
        tbl[5] = '{1'b0, 9'd0, 2'd0, 8'h00, 1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 9'd3};
        tbl[6] = '{1'b0, 9'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 9'd4};
        tbl[7] = '{1'b1, 9'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 9'd4};
        tbl[8] = '{1'b0, 9'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 9'd0};
        tbl[9] = '{1'b0, 9'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 9'd0};

        // Reset values while held in reset
        #2;
        chk("rst_wreq", {31'd0, wreq0}, 0);
        chk("rst_wd", {24'd0, wd0}, 0);
        chk("rst_busy", {31'd0, busy0}, 0);
        chk("rst_done", {31'd0, done0}, 0);
        chk("rst_count", {23'd0, count0}, 0);
        chk("rst_din_ready", {31'd0, din_ready0}, 0);
        chk("rst_count3", {23'd0, count3}, 0);
        tick(); tick();
        rst = 1;
        tick();

        // Table-driven cycle-by-cycle vectors on the GAP=0 instance
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].start; len = tbl[i].len; mode = tbl[i].mode;
            seed = tbl[i].seed; f = tbl[i].f;
            #1;
            chk($sformatf("vec%0d_wreq", i), {31'd0, wreq0}, {31'd0, tbl[i].e_wreq});
            chk($sformatf("vec%0d_wd", i), {24'd0, wd0}, {24'd0, tbl[i].e_wd});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy0}, {31'd0, tbl[i].e_busy});
            chk($sformatf("vec%0d_done", i), {31'd0, done0}, {31'd0, tbl[i].e_done});
            chk($sformatf("vec%0d_count", i), {23'd0, count0}, {23'd0, tbl[i].e_count});
            tick();
        end

        // Increment mode from F0, 20 back-to-back beats wrapping through 00
        reset_sync();
        start = 1; len = 9'd20; mode = 2'd1; seed = 8'hF0;
        tick();
        start = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("inc_wreq", {31'd0, wreq0}, 1);
            chk("inc_wd", {24'd0, wd0}, {24'd0, 8'(8'hF0 + i)});
            tick();
        end
        #1;
        chk("inc_done", {31'd0, done0}, 1);
        chk("inc_count", {23'd0, count0}, 20);
        chk("inc_wreq_after", {31'd0, wreq0}, 0);

        // 256-byte constant burst with the FIFO full for cycles 10..30
        reset_sync();
        q0.delete();
        d = dn0;
        start = 1; len = 9'd256; mode = 2'd0; seed = 8'h5A;
        tick();
        start = 0;
        c = 0;
        while (dn0 == d && c < 1000) begin
            f = (c >= 10 && c <= 30);
            #1;
            if (f) begin
                chk("full_wreq", {31'd0, wreq0}, 0);
                chk("full_wd", {24'd0, wd0}, 32'h5A);
            end
            tick();
            c++;
        end
        f = 0;
        chk("full_timeout", {31'd0, c < 1000}, 1);
        chk("full_beats", q0.size(), 256);
        chk("full_count", {23'd0, count0}, 256);
        bad = 0;
        foreach (q0[i]) if (q0[i] !== 8'h5A) bad++;
        chk("full_data", bad, 0);

        // GAP=3 instance: 3 beats spaced by 3 idle cycles, start while busy ignored
        reset_sync();
        q3.delete(); bt.delete();
        start = 1; len = 9'd3; mode = 2'd1; seed = 8'h10;
        tick();
        c = 0;
        while (c < 100) begin
            start = (c == 2);
            len = (c == 2) ? 9'd5 : 9'd3;
            #1;
            if (done3) break;
            if (wreq3) bt.push_back(c);
            tick();
            c++;
        end
        start = 0;
        chk("gap_beats", bt.size(), 3);
        if (bt.size() == 3) begin
            chk("gap_space1", bt[1] - bt[0], 4);
            chk("gap_space2", bt[2] - bt[1], 4);
        end
        chk("gap_count", {23'd0, count3}, 3);
        chk("gap_q_size", q3.size(), 3);
        if (q3.size() == 3) chk("gap_last", {24'd0, q3[2]}, 32'h12);
        tick();
        chk("gap_idle_count", {23'd0, count3}, 3);

        // External mode with random din_valid, aborted after 5 beats
        reset_sync();
        q0.delete(); src0.delete();
        d = dn0;
        start = 1; len = 9'd50; mode = 2'd3; seed = 8'h00;
        tick();
        start = 0;
        c = 0;
        while (q0.size() < 5 && c < 500) begin
            din_valid = ($urandom_range(0, 1) == 1);
            din = 8'($urandom);
            tick();
            c++;
        end
        din_valid = 0;
        chk("ext_timeout", {31'd0, c < 500}, 1);
        abort = 1;
        tick();
        abort = 0;
        #1;
        chk("abort_busy", {31'd0, busy0}, 0);
        chk("abort_count", {23'd0, count0}, 5);
        repeat (3) tick();
        chk("abort_no_done", dn0 - d, 0);
        chk("abort_count_hold", {23'd0, count0}, 5);
        chk("ext_beats", q0.size(), 5);
        chk("ext_src", src0.size(), 5);
        bad = 0;
        foreach (q0[i]) if (i >= src0.size() || q0[i] !== src0[i]) bad++;
        chk("ext_order", bad, 0);

        // Reset mid-burst clears outputs at once; then a len=0 start
        reset_sync();
        start = 1; len = 9'd30; mode = 2'd1; seed = 8'h33;
        tick();
        start = 0;
        repeat (4) tick();
        rst = 0;
        #1;
        chk("mid_rst_wreq", {31'd0, wreq0}, 0);
        chk("mid_rst_wd", {24'd0, wd0}, 0);
        chk("mid_rst_busy", {31'd0, busy0}, 0);
        chk("mid_rst_count", {23'd0, count0}, 0);
        chk("mid_rst_busy3", {31'd0, busy3}, 0);
        tick();
        rst = 1;
        tick();
        q0.delete();
        d = dn0;
        start = 1; len = 9'd0;
        tick();
        start = 0;
        #1;
        chk("len0_done", {31'd0, done0}, 1);
        chk("len0_wreq", {31'd0, wreq0}, 0);
        tick();
        #1;
        chk("len0_done_end", {31'd0, done0}, 0);
        chk("len0_pulses", dn0 - d, 1);
        chk("len0_beats", q0.size(), 0);

        // Randomised bursts against the stream model on both instances
        reset_sync();
        for (int b = 0; b < 24; b++) begin
            l  = (b == 7) ? 9'd256 : 9'($urandom_range(0, 24));
            m  = 2'($urandom_range(0, 3));
            s  = 8'($urandom);
            rf = ($urandom_range(0, 1) == 1);
            if (b == 3) begin m = 2'd2; s = 8'h00; end
            run_burst(l, m, s, rf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
